// File: rtl/seq_divider_u8.sv
// Sequential unsigned restoring divider: one quotient bit per clock.
// Divide-by-zero returns all-ones quotient and the dividend as remainder immediately.
module seq_divider_u8 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] r_q, r_d, q_q, q_d, dvs_q, dvs_d;
    logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d;
    logic             done_q, done_d, dbz_q, dbz_d;
    logic [WIDTH:0]   r_sh, trial;

    always_comb begin
        // Partial remainder stays below the divisor, so a non-negative trial fits in WIDTH bits
        // and the top bit of the WIDTH+1 result is a clean borrow flag.
        r_sh    = {r_q, q_q[WIDTH-1]};
        trial   = r_sh - {1'b0, dvs_q};
        state_d = state_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        q_d     = q_q;
        dvs_d   = dvs_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (divisor != '0) begin
                        dvs_d   = divisor;
                        r_d     = '0;
                        q_d     = dividend;
                        cnt_d   = CW'(WIDTH);
                        state_d = S_RUN;
                    end else begin
                        done_d = 1'b1;
                        quo_d  = '1;
                        rem_d  = dividend;
                        dbz_d  = 1'b1;
                    end
                end
            end
            S_RUN: begin
                r_d   = trial[WIDTH] ? r_sh[WIDTH-1:0] : trial[WIDTH-1:0];
                q_d   = {q_q[WIDTH-2:0], ~trial[WIDTH]};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    quo_d   = q_d;
                    rem_d   = r_d;
                    dbz_d   = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            r_q     <= '0;
            q_q     <= '0;
            dvs_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            q_q     <= q_d;
            dvs_q   <= dvs_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            done_q  <= done_d;
        end
    end

    assign busy        = (state_q == S_RUN);
    assign done        = done_q;
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_divider_u8.sv
// Scoreboard bench for seq_divider_u8: driver pushes expected results, monitor pops on done.
module tb_seq_divider_u8;
    typedef struct packed {
        logic [7:0] q;
        logic [7:0] r;
        logic       z;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] dividend = '0, divisor = '0;
    logic       busy, done, div_by_zero;
    logic [7:0] quotient, remainder;

    exp_t sb[$];
    int   n_checks = 0, n_fail = 0;
    int   n_accept = 0, n_done = 0;

    seq_divider_u8 #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Monitor: compare every done pulse against the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            n_done++;
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_done: q=%0d r=%0d dbz=%0d with empty scoreboard",
                         quotient, remainder, div_by_zero);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if ({quotient, remainder, div_by_zero} !== e) begin
                    n_fail++;
                    $display("FAIL result: got q=%0d r=%0d dbz=%0d, expected q=%0d r=%0d dbz=%0d",
                             quotient, remainder, div_by_zero, e.q, e.r, e.z);
                end
            end
        end
    end

    // Caller guarantees the DUT is idle in the current cycle.
    task automatic issue(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] eq, input logic [7:0] er, input logic ez);
        start = 1'b1; dividend = a; divisor = b;
        sb.push_back('{q: eq, r: er, z: ez});
        n_accept++;
        @(posedge clk); #1;
        start = 1'b0; dividend = $urandom; divisor = $urandom;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((sb.size() != 0 || busy) && k < 40) begin
            @(negedge clk); #1;
            k++;
        end
        if (sb.size() != 0 || busy) begin
            n_checks++; n_fail++;
            $display("FAIL drain_timeout: %0d results outstanding", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_q", quotient, 0);
        check("reset_r", remainder, 0);
        check("reset_dbz", div_by_zero, 0);

        // 200/7 with cycle-accurate timing and output stability during RUN
        #1 issue(8'd200, 8'd7, 8'd28, 8'd4, 1'b0);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            check("run_busy", busy, 1);
            check("run_no_done", done, 0);
            check("run_q_hold", quotient, 0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("latency_done", done, 1);
        check("latency_busy", busy, 0);
        drain();

        issue(8'd255, 8'd1, 8'd255, 8'd0, 1'b0);   drain();
        issue(8'd5, 8'd9, 8'd0, 8'd5, 1'b0);       drain();
        issue(8'd0, 8'd3, 8'd0, 8'd0, 1'b0);       drain();
        issue(8'd255, 8'd255, 8'd1, 8'd0, 1'b0);   drain();

        // divide by zero: result next cycle, busy never rises
        issue(8'd77, 8'd0, 8'd255, 8'd77, 1'b1);
        @(negedge clk);
        check("dbz_done", done, 1);
        check("dbz_busy", busy, 0);
        drain();

        // start while busy is ignored
        issue(8'd100, 8'd9, 8'd11, 8'd1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        start = 1'b1; dividend = 8'd10; divisor = 8'd3;
        @(posedge clk); #1 start = 1'b0;
        drain();
        check("midrun_ignored_busy", busy, 0);

        // back-to-back: second start lands in the done cycle
        issue(8'd50, 8'd6, 8'd8, 8'd2, 1'b0);
        begin
            int k;
            k = 0;
            while (!done && k < 20) begin @(negedge clk); #1; k++; end
            check("b2b_done_seen", done, 1);
        end
        issue(8'd9, 8'd4, 8'd2, 8'd1, 1'b0);
        drain();

        // reset mid-run aborts without a done pulse
        start = 1'b1; dividend = 8'd200; divisor = 8'd7;
        @(posedge clk); #1 start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_q", quotient, 0);
        check("abort_r", remainder, 0);
        rst = 1'b0;
        #1 issue(8'd200, 8'd7, 8'd28, 8'd4, 1'b0);
        drain();

        // strided sweep including zero divisors
        for (int a = 0; a < 256; a += 17) begin
            for (int b = 0; b < 256; b += 23) begin
                if (b == 0) issue(8'(a), 8'(b), 8'd255, 8'(a), 1'b1);
                else        issue(8'(a), 8'(b), 8'(a / b), 8'(a % b), 1'b0);
                drain();
            end
        end

        repeat (3) @(negedge clk);
        check("done_count", n_done, n_accept);
        check("scoreboard_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
